// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the IF-stage next-PC generator.
//   rd_class_e      - redirect source class, ordered from lowest to highest priority
//   DEF_XLEN        - default address width
//   DEF_INSTR_BYTES - default sequential fetch increment in bytes
package pc_gen_pkg;

   typedef enum logic [2:0] {
      RD_NONE  = 3'd0,
      RD_JUMP  = 3'd1,
      RD_RET   = 3'd2,
      RD_FLUSH = 3'd3,
      RD_TRAP  = 3'd4
   } rd_class_e;

   localparam int DEF_XLEN        = 64;
   localparam int DEF_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset_n     - clock, asynchronous active-low reset
//   push, push_addr  - push a return address (writes slot top+1)
//   pop              - pop the top entry (caller only pops a non-empty stack)
//   clear            - discard all entries (count -> 0)
//   top              - current top entry
//   count            - number of valid entries, saturating at RAS_DEPTH
//   empty            - count == 0
// When full, a push wraps the pointer and silently overwrites the oldest entry.
module pc_ras #(
   parameter int XLEN      = 64,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [XLEN-1:0]              push_addr,
   output logic [XLEN-1:0]              top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         empty
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] mem_reg [RAS_DEPTH];
   logic [PW-1:0]   ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            full;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;

   assign top   = mem_reg[ptr_reg];
   assign count = count_reg;
   assign empty = (count_reg == '0);
   assign full  = (count_reg == DEPTH_C);

   // Push+pop together replaces the top slot in place; a lone push writes above it.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = ptr_reg + 1'b1;
      if (!clear && push) begin
         wr_en = 1'b1;
         if (pop && !empty) wr_idx = ptr_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               mem_reg[gi] <= '0;
            else if (wr_en && (wr_idx == PW'(gi)))
               mem_reg[gi] <= push_addr;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg   <= '0;
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (push && !(pop && !empty)) begin
         ptr_reg <= ptr_reg + 1'b1;
         if (!full) count_reg <= count_reg + 1'b1;
      end else if (pop && !push && !empty) begin
         ptr_reg   <= ptr_reg - 1'b1;
         count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: next-PC generator for the IF stage.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   stall                        - hold PC; only trap/flush are remembered while stalled
//   trap_valid/trap_target       - exception/interrupt redirect (highest class)
//   flush_valid/flush_target     - EX mispredict/flush redirect
//   jump_valid/jump_target       - ID direct-jump redirect
//   ret_valid                    - ID return: pop RAS and redirect to its top
//   ras_push/ras_push_addr       - ID call: push return address
//   pc_out                       - current fetch PC (registered)
//   pc_plus                      - pc_out + INSTR_BYTES
//   redirect_pend                - a trap/flush captured during stall is waiting
//   ras_count                    - valid RAS entries
//   ras_miss                     - one-cycle pulse after a return found the RAS empty
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        stall,
   input  logic                        trap_valid,
   input  logic [XLEN-1:0]             trap_target,
   input  logic                        flush_valid,
   input  logic [XLEN-1:0]             flush_target,
   input  logic                        jump_valid,
   input  logic [XLEN-1:0]             jump_target,
   input  logic                        ret_valid,
   input  logic                        ras_push,
   input  logic [XLEN-1:0]             ras_push_addr,
   output logic [XLEN-1:0]             pc_out,
   output logic [XLEN-1:0]             pc_plus,
   output logic                        redirect_pend,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_miss
);
   logic [XLEN-1:0] pc_reg;
   logic            pend_reg;
   rd_class_e       pend_class_reg;
   logic [XLEN-1:0] pend_target_reg;
   logic            ras_miss_reg;

   rd_class_e       sel;
   logic [XLEN-1:0] pc_next;
   logic            pend_trap;
   logic            hi_taken;
   logic            ras_empty;
   logic [XLEN-1:0] ras_top;

   assign pc_out        = pc_reg;
   assign pc_plus       = pc_reg + XLEN'(INSTR_BYTES);
   assign redirect_pend = pend_reg;
   assign ras_miss      = ras_miss_reg;
   assign pend_trap     = pend_reg && (pend_class_reg == RD_TRAP);

   // Class ordering: a held trap outranks a live flush, a held flush is
   // outranked by a live flush (newer wins) and outranks ret/jump.
   always_comb begin
      sel     = RD_NONE;
      pc_next = pc_plus;
      if (trap_valid) begin
         sel     = RD_TRAP;
         pc_next = trap_target;
      end else if (pend_trap) begin
         sel     = RD_TRAP;
         pc_next = pend_target_reg;
      end else if (flush_valid) begin
         sel     = RD_FLUSH;
         pc_next = flush_target;
      end else if (pend_reg) begin
         sel     = RD_FLUSH;
         pc_next = pend_target_reg;
      end else if (ret_valid && !ras_empty) begin
         sel     = RD_RET;
         pc_next = ras_top;
      end else if (jump_valid) begin
         sel     = RD_JUMP;
         pc_next = jump_target;
      end
   end

   // Any trap/flush-class redirect means the ID call/return is on the wrong path.
   assign hi_taken = (sel == RD_TRAP) || (sel == RD_FLUSH);

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (!stall && ras_push && !hi_taken),
      .pop       (!stall && (sel == RD_RET)),
      .clear     (!stall && (sel == RD_TRAP)),
      .push_addr (ras_push_addr),
      .top       (ras_top),
      .count     (ras_count),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg          <= RESET_VECTOR;
         pend_reg        <= 1'b0;
         pend_class_reg  <= RD_NONE;
         pend_target_reg <= '0;
         ras_miss_reg    <= 1'b0;
      end else if (stall) begin
         ras_miss_reg <= 1'b0;
         // A trap always overwrites; a flush never displaces a held trap.
         if (trap_valid) begin
            pend_reg        <= 1'b1;
            pend_class_reg  <= RD_TRAP;
            pend_target_reg <= trap_target;
         end else if (flush_valid && !pend_trap) begin
            pend_reg        <= 1'b1;
            pend_class_reg  <= RD_FLUSH;
            pend_target_reg <= flush_target;
         end
      end else begin
         pc_reg         <= pc_next;
         pend_reg       <= 1'b0;
         pend_class_reg <= RD_NONE;
         ras_miss_reg   <= ret_valid && ras_empty && !hi_taken;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test of pc_gen with a queue-based reference model
// compared every cycle, plus literal checks for the documented scenarios.
module tb_pc_gen;
   localparam int XLEN  = 64;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            stall, trap_valid, flush_valid, jump_valid, ret_valid, ras_push;
   logic [XLEN-1:0] trap_target, flush_target, jump_target, ras_push_addr;
   logic [XLEN-1:0] pc_out, pc_plus;
   logic            redirect_pend, ras_miss;
   logic [2:0]      ras_count;

   pc_gen #(
      .XLEN         (XLEN),
      .RESET_VECTOR (64'h1000),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .trap_valid    (trap_valid),
      .trap_target   (trap_target),
      .flush_valid   (flush_valid),
      .flush_target  (flush_target),
      .jump_valid    (jump_valid),
      .jump_target   (jump_target),
      .ret_valid     (ret_valid),
      .ras_push      (ras_push),
      .ras_push_addr (ras_push_addr),
      .pc_out        (pc_out),
      .pc_plus       (pc_plus),
      .redirect_pend (redirect_pend),
      .ras_count     (ras_count),
      .ras_miss      (ras_miss)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   // Reference model state
   logic [XLEN-1:0] m_pc;
   bit              m_pend, m_pend_trap, m_miss;
   logic [XLEN-1:0] m_pend_tgt;
   logic [XLEN-1:0] m_ras[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = 64'h1000; m_pend = 0; m_pend_trap = 0; m_pend_tgt = '0; m_miss = 0;
      m_ras.delete();
   endtask

   task automatic model_step();
      int  n;
      bit  hi, trapc;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (stall) begin
         if (trap_valid) begin
            m_pend = 1; m_pend_trap = 1; m_pend_tgt = trap_target;
         end else if (flush_valid && !(m_pend && m_pend_trap)) begin
            m_pend = 1; m_pend_trap = 0; m_pend_tgt = flush_target;
         end
         m_miss = 0;
         return;
      end
      n = m_ras.size(); hi = 0; trapc = 0;
      if (trap_valid)                begin m_pc = trap_target;  hi = 1; trapc = 1; end
      else if (m_pend && m_pend_trap) begin m_pc = m_pend_tgt;  hi = 1; trapc = 1; end
      else if (flush_valid)          begin m_pc = flush_target; hi = 1; end
      else if (m_pend)               begin m_pc = m_pend_tgt;   hi = 1; end
      else if (ret_valid && n > 0)   m_pc = m_ras[n-1];
      else if (jump_valid)           m_pc = jump_target;
      else                           m_pc = m_pc + 64'd4;
      m_miss = ret_valid && !hi && (n == 0);
      if (trapc) m_ras.delete();
      else if (!hi) begin
         if (ret_valid && n > 0) begin
            if (ras_push) m_ras[n-1] = ras_push_addr;
            else void'(m_ras.pop_back());
         end else if (ras_push) begin
            m_ras.push_back(ras_push_addr);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
      end
      m_pend = 0;
   endtask

   // One clock: model advances on the same edge as the DUT, inputs settle 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clr();
      stall = 0; trap_valid = 0; flush_valid = 0; jump_valid = 0; ret_valid = 0; ras_push = 0;
      trap_target = '0; flush_target = '0; jump_target = '0; ras_push_addr = '0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_out",        pc_out,        m_pc);
         chk("pc_plus",       pc_plus,       m_pc + 64'd4);
         chk("redirect_pend", 64'(redirect_pend), 64'(m_pend));
         chk("ras_count",     64'(ras_count),     64'(m_ras.size()));
         chk("ras_miss",      64'(ras_miss),      64'(m_miss));
      end
   end

   initial begin
      reset_n = 1'b1;
      clr();
      model_reset();
      repeat (2) @(posedge clk);
      // 1: asynchronous reset mid-cycle
      #3 reset_n = 1'b0;
      model_reset();
      #1;
      chk("reset_pc_async", pc_out, 64'h1000);
      chk("reset_pend", 64'(redirect_pend), 64'd0);
      chk("reset_ras_count", 64'(ras_count), 64'd0);
      chk_en = 1'b1;
      tick();
      #3 reset_n = 1'b1;
      tick(); chk("seq1", pc_out, 64'h1004);
      tick(); chk("seq2", pc_out, 64'h1008);
      tick(); chk("seq3", pc_out, 64'h100C);
      $display("txn reset+sequential pc=%h", pc_out);

      // 2: flush captured during stall
      stall = 1; tick();
      flush_valid = 1; flush_target = 64'h2000; tick();
      chk("stall_hold", pc_out, 64'h100C);
      chk("pend_set", 64'(redirect_pend), 64'd1);
      flush_valid = 0; tick();
      stall = 0; tick();
      chk("pend_release_pc", pc_out, 64'h2000);
      chk("pend_cleared", 64'(redirect_pend), 64'd0);
      $display("txn stalled flush pc=%h", pc_out);

      // 3: trap outranks held/later flushes
      stall = 1; flush_valid = 1; flush_target = 64'h2000; tick();
      flush_valid = 0; trap_valid = 1; trap_target = 64'h8000; tick();
      trap_valid = 0; flush_valid = 1; flush_target = 64'h3000; tick();
      clr(); tick();
      chk("trap_over_flush", pc_out, 64'h8000);
      trap_valid = 1; trap_target = 64'h9000; flush_valid = 1; flush_target = 64'h5000; tick();
      chk("live_trap_wins", pc_out, 64'h9000);
      clr();
      // held flush beats a live jump
      stall = 1; flush_valid = 1; flush_target = 64'h6000; tick();
      clr(); jump_valid = 1; jump_target = 64'h7000; tick();
      chk("pend_over_jump", pc_out, 64'h6000);
      clr();
      $display("txn priority pc=%h", pc_out);

      // 4: RAS overflow and underflow
      for (int i = 0; i < 5; i++) begin
         ras_push = 1; ras_push_addr = 64'hA0 + 64'(i) * 64'h10; tick();
      end
      clr();
      chk("ras_full_count", 64'(ras_count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         ret_valid = 1; tick();
         chk("ras_pop_target", pc_out, 64'hE0 - 64'(i) * 64'h10);
      end
      chk("ras_empty_count", 64'(ras_count), 64'd0);
      ret_valid = 1; tick();
      chk("ras_miss_pulse", 64'(ras_miss), 64'd1);
      chk("ras_miss_seq_pc", pc_out, 64'hB4);
      clr(); tick();
      chk("ras_miss_clears", 64'(ras_miss), 64'd0);
      $display("txn ras overflow/underflow pc=%h", pc_out);

      // 5: push+pop replace, trap clears
      ras_push = 1; ras_push_addr = 64'h30; tick();
      ret_valid = 1; ras_push_addr = 64'h40; tick();
      chk("pushpop_redirect", pc_out, 64'h30);
      chk("pushpop_count", 64'(ras_count), 64'd1);
      ras_push = 0; tick();
      chk("pushpop_new_top", pc_out, 64'h40);
      ret_valid = 0; ras_push = 1; ras_push_addr = 64'h50; tick();
      clr(); trap_valid = 1; trap_target = 64'h100; tick();
      chk("trap_clears_ras", 64'(ras_count), 64'd0);
      clr();
      $display("txn ras replace/clear pc=%h", pc_out);

      // 6: wraparound and jump ignored under stall
      jump_valid = 1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC; tick();
      clr();
      chk("wrap_pc_plus", pc_plus, 64'd0);
      tick();
      chk("wrap_pc", pc_out, 64'd0);
      stall = 1; jump_valid = 1; jump_target = 64'h7000; tick();
      chk("stall_jump_ignored", pc_out, 64'd0);
      clr(); tick();
      chk("after_stall_seq", pc_out, 64'd4);
      $display("txn wrap/stall-jump pc=%h", pc_out);

      @(negedge clk);
      #1 chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
